// File: rtl/pattern_det_param_moore_if.sv
// Serial pattern detector bus: sample/control inputs and match outputs.
interface pattern_det_param_moore_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             x;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             clr_cnt;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    // Driver side (stimulus / upstream control logic)
    modport master (
        output en, x, load, pat_in, overlap, clr_cnt,
        input  y, match_cnt, cnt_sat
    );

    // Detector side
    modport slave (
        input  en, x, load, pat_in, overlap, clr_cnt,
        output y, match_cnt, cnt_sat
    );
endinterface

// File: rtl/pattern_det_param_moore.sv
// Parametrised serial pattern detector with a registered (Moore) match flag,
// runtime-loadable pattern, selectable overlap and a saturating match counter.
module pattern_det_param_moore #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
    parameter int unsigned      CNT_W   = 8
) (
    input logic                    clk,
    input logic                    rst,
    pattern_det_param_moore_if.slave bus
);

    localparam int unsigned      FillW   = $clog2(PAT_W);
    localparam logic [FillW-1:0] FillMax = FillW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StFilling,
        StArmed
    } state_e;

    state_e           state_q, state_d;
    logic [FillW-1:0] fill_q,  fill_d;
    logic [PAT_W-2:0] hist_q,  hist_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic             y_q,     y_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;

    logic [PAT_W-1:0] window;
    logic             hit;

    // State registers; reset aborts any partial match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFilling;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= PAT_RST;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Search FSM next state: load restarts, enabled bits shift in and are matched
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        y_d     = y_q;

        // Oldest bit lands in the MSB, matching the pattern's bit order
        window = {hist_q, bus.x};
        hit    = bus.en & ~bus.load & (state_q == StArmed) & (window == pat_q);

        if (bus.load) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
            y_d    = 1'b0;
        end else if (bus.en) begin
            hist_d = window[PAT_W-2:0];
            y_d    = hit;
            if (hit && !bus.overlap) begin
                // Non-overlapping: the next match needs a full fresh pattern
                fill_d = '0;
            end else if (fill_q != FillMax) begin
                fill_d = fill_q + 1'b1;
            end
        end

        state_d = (fill_d == FillMax) ? StArmed : StFilling;
    end

    // Saturating match counter; clear beats a coincident hit
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
            sat_d = (cnt_d == CntMax);
        end
    end

    assign bus.y         = y_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;

endmodule
